// File: rtl/cve2_rf_write_sched_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
package cve2_rf_write_sched_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic {
        RfSchedInit,
        RfSchedRun
    } rf_sched_state_e;

    typedef enum logic [2:0] {
        WsrcNone,
        WsrcInit,
        WsrcBuf,
        WsrcEx,
        WsrcLsu
    } rf_wsrc_e;

    function automatic int unsigned num_words(bit rv32e);
        return rv32e ? 16 : 32;
    endfunction

    // RV32E only decodes x0..x15, so bit 4 is forced low.
    function automatic logic [RegAddrW-1:0] mask_addr(bit rv32e, logic [RegAddrW-1:0] addr);
        return rv32e ? {1'b0, addr[3:0]} : addr;
    endfunction

endpackage

// File: rtl/cve2_rf_write_sched_if.sv
// Write-request / register-file bus between ID/EX, the LSU and the write scheduler.
interface cve2_rf_write_sched_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 32
);
    logic                 ex_req_i;
    logic [4:0]           ex_addr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 ex_gnt_o;
    logic                 lsu_valid_i;
    logic [4:0]           lsu_addr_i;
    logic [DataWidth-1:0] lsu_wdata_i;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [NumWords-1:0]  rf_pend_o;
    logic                 init_busy_o;

    modport master (
        output ex_req_i, ex_addr_i, ex_wdata_i, lsu_valid_i, lsu_addr_i, lsu_wdata_i,
        input  ex_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_pend_o, init_busy_o
    );

    modport slave (
        input  ex_req_i, ex_addr_i, ex_wdata_i, lsu_valid_i, lsu_addr_i, lsu_wdata_i,
        output ex_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_pend_o, init_busy_o
    );
endinterface

// File: rtl/cve2_rf_write_sched_clear_seq.sv
// Address counter for the post-reset register clear; walks 1..NumWords-1.
module cve2_rf_clear_seq #(
    parameter int unsigned NumWords = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [4:0] addr_o,
    output logic       last_o
);
    logic [4:0] cnt_q;

    // Counter parks on the last address so it never wraps back onto x0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 5'd1;
        end else if (en_i && !last_o) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign addr_o = cnt_q;
    assign last_o = (cnt_q == 5'(NumWords - 1));
endmodule

// File: rtl/cve2_rf_write_sched.sv
// Single-write-port register-file scheduler: EX vs. LSU arbitration with a
// one-entry LSU overflow buffer and a post-reset clear sequence.
module cve2_rf_write_sched
    import cve2_rf_write_sched_pkg::*;
#(
    parameter bit                   RV32E        = 1'b0,
    parameter int unsigned          DataWidth    = 32,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0,
    parameter bit                   ClearOnReset = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cve2_rf_write_sched_if.slave bus
);
    localparam int unsigned NumWords = num_words(RV32E);

    rf_sched_state_e      state_q, state_d;
    rf_wsrc_e             wsrc;
    logic                 buf_vld_q;
    logic [RegAddrW-1:0]  buf_addr_q;
    logic [DataWidth-1:0] buf_data_q;
    logic                 buf_set, buf_clr;
    logic [RegAddrW-1:0]  ex_addr, lsu_addr, clr_addr, waddr;
    logic [DataWidth-1:0] wdata;
    logic                 clr_en, clr_last;
    logic                 refill;
    logic [1:0]           refill_cnt_q;

    assign ex_addr  = mask_addr(RV32E, bus.ex_addr_i);
    assign lsu_addr = mask_addr(RV32E, bus.lsu_addr_i);
    assign clr_en   = rst_ni && (state_q == RfSchedInit);

    cve2_rf_clear_seq #(.NumWords(NumWords)) u_clear_seq (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (clr_en),
        .addr_o (clr_addr),
        .last_o (clr_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ClearOnReset ? RfSchedInit : RfSchedRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: clear sequence, buffered LSU entry, EX, direct LSU.
    always_comb begin
        state_d = state_q;
        wsrc    = WsrcNone;
        buf_set = 1'b0;
        buf_clr = 1'b0;
        if (state_q == RfSchedInit) begin
            wsrc = WsrcInit;
            if (clr_last) state_d = RfSchedRun;
        end else if (buf_vld_q) begin
            wsrc    = WsrcBuf;
            buf_set = bus.lsu_valid_i;
            buf_clr = !bus.lsu_valid_i;
        end else if (bus.ex_req_i) begin
            wsrc    = WsrcEx;
            buf_set = bus.lsu_valid_i;
        end else if (bus.lsu_valid_i) begin
            wsrc = WsrcLsu;
        end
    end

    always_comb begin
        waddr = '0;
        wdata = '0;
        unique case (wsrc)
            WsrcInit: begin waddr = clr_addr;   wdata = WordZeroVal;    end
            WsrcBuf:  begin waddr = buf_addr_q; wdata = buf_data_q;     end
            WsrcEx:   begin waddr = ex_addr;    wdata = bus.ex_wdata_i; end
            WsrcLsu:  begin waddr = lsu_addr;   wdata = bus.lsu_wdata_i; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_vld_q <= 1'b0;
        end else if (buf_set) begin
            buf_vld_q <= 1'b1;
        end else if (buf_clr) begin
            buf_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_set) begin
            buf_addr_q <= lsu_addr;
            buf_data_q <= bus.lsu_wdata_i;
        end
    end

    // Everything is forced quiet while reset is asserted, whatever the state.
    assign bus.ex_gnt_o    = rst_ni && (wsrc == WsrcEx);
    assign bus.rf_we_o     = rst_ni && (wsrc != WsrcNone) && (waddr != '0);
    assign bus.rf_waddr_o  = rst_ni ? waddr : '0;
    assign bus.rf_wdata_o  = rst_ni ? wdata : '0;
    assign bus.rf_pend_o   = (rst_ni && buf_vld_q && (buf_addr_q != '0))
                             ? (NumWords'(1) << buf_addr_q) : '0;
    assign bus.init_busy_o = rst_ni && (state_q == RfSchedInit);

    assign refill = buf_vld_q && bus.lsu_valid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !refill) begin
            refill_cnt_q <= 2'd0;
        end else if (refill_cnt_q != 2'd3) begin
            refill_cnt_q <= refill_cnt_q + 2'd1;
        end
    end

    a_no_lsu_in_init: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == RfSchedInit) |-> !bus.lsu_valid_i);
    a_we_not_x0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.rf_we_o |-> (bus.rf_waddr_o != 5'd0));
    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.ex_gnt_o |-> bus.ex_req_i);
    a_refill_burst: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(refill && (refill_cnt_q >= 2'd2)));
endmodule

// File: tb/tb_cve2_rf_write_sched.sv
// Randomized and directed bench for the register-file write scheduler with a
// queue-based reference model and a shadow register file.
module tb_cve2_rf_write_sched;
    localparam logic [31:0] ZeroVal = 32'h1357_9BDF;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    int          n_chk = 0;
    int          n_err = 0;
    ent_t        pq[$];
    logic [31:0] exp_rf [32];
    logic [31:0] act_rf [32];
    int          init_left;
    logic [4:0]  init_addr;
    logic        g;
    logic        er, lv, lv_prev;
    logic [4:0]  ea, la;
    logic [31:0] ed, ld;

    always #5 clk = ~clk;

    cve2_rf_write_sched_if #(.DataWidth(32), .NumWords(32)) bus ();

    cve2_rf_write_sched #(
        .RV32E        (1'b0),
        .DataWidth    (32),
        .WordZeroVal  (ZeroVal),
        .ClearOnReset (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] a, input logic [31:0] d,
                         input logic v, input logic [4:0] la_i, input logic [31:0] ld_i);
        bus.ex_req_i    = r;
        bus.ex_addr_i   = a;
        bus.ex_wdata_i  = d;
        bus.lsu_valid_i = v;
        bus.lsu_addr_i  = la_i;
        bus.lsu_wdata_i = ld_i;
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        drive(1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1, 5'd4, 32'h1234_5678);
        repeat (n) begin
            #4;
            chk("rst_gnt",   bus.ex_gnt_o,    1'b0);
            chk("rst_we",    bus.rf_we_o,     1'b0);
            chk("rst_waddr", bus.rf_waddr_o,  5'd0);
            chk("rst_wdata", bus.rf_wdata_o,  32'd0);
            chk("rst_pend",  bus.rf_pend_o,   32'd0);
            chk("rst_busy",  bus.init_busy_o, 1'b0);
            @(posedge clk);
            #1;
        end
        rst_ni = 1'b1;
        pq.delete();
        init_left = 31;
        init_addr = 5'd1;
    endtask

    // One clock cycle: drive, predict from the model, compare mid-cycle, advance.
    task automatic step(input logic r, input logic [4:0] a, input logic [31:0] d,
                        input logic v, input logic [4:0] la_i, input logic [31:0] ld_i,
                        output logic gnt);
        logic        e_gnt, e_we, e_busy, push, pop;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_pend;
        drive(r, a, d, v, la_i, ld_i);
        e_gnt = 1'b0; e_we = 1'b0; e_a = 5'd0; e_d = 32'd0; push = 1'b0; pop = 1'b0;
        e_busy = (init_left > 0);
        e_pend = (pq.size() > 0 && pq[0].a != 5'd0) ? (32'h1 << pq[0].a) : 32'h0;
        if (init_left > 0) begin
            e_we = 1'b1; e_a = init_addr; e_d = ZeroVal;
        end else if (pq.size() > 0) begin
            e_a = pq[0].a; e_d = pq[0].d; e_we = (e_a != 5'd0); pop = 1'b1; push = v;
        end else if (r) begin
            e_gnt = 1'b1; e_a = a; e_d = d; e_we = (a != 5'd0); push = v;
        end else if (v) begin
            e_a = la_i; e_d = ld_i; e_we = (la_i != 5'd0);
        end
        #4;
        chk("ex_gnt",    bus.ex_gnt_o,    e_gnt);
        chk("rf_we",     bus.rf_we_o,     e_we);
        chk("init_busy", bus.init_busy_o, e_busy);
        chk("rf_pend",   bus.rf_pend_o,   e_pend);
        if (e_we && bus.rf_we_o) begin
            chk("rf_waddr", bus.rf_waddr_o, e_a);
            chk("rf_wdata", bus.rf_wdata_o, e_d);
        end
        if (bus.rf_we_o) act_rf[bus.rf_waddr_o] = bus.rf_wdata_o;
        if (e_we) exp_rf[e_a] = e_d;
        if (pop) void'(pq.pop_front());
        if (push) pq.push_back('{a: la_i, d: ld_i});
        if (init_left > 0) begin
            init_left--;
            init_addr++;
        end
        gnt = e_gnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            exp_rf[r] = 32'd0;
            act_rf[r] = 32'd0;
        end
        init_left = 0;
        init_addr = 5'd1;
        do_reset(2);

        // Clear sequence with an EX request waiting; it is granted in the first RUN cycle.
        repeat (31) step(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, g);
        step(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, g);

        // EX and LSU collide: LSU is buffered, then drained ahead of the next EX.
        step(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd7, 32'h0000_0777, g);
        step(1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0, g);
        step(1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0, g);

        // Buffer freed and refilled in the same cycle.
        step(1'b1, 5'd10, 32'h0000_AAAA, 1'b1, 5'd8, 32'h0000_8888, g);
        step(1'b1, 5'd10, 32'h0000_AAAA, 1'b1, 5'd9, 32'h0000_9999, g);
        step(1'b1, 5'd10, 32'h0000_AAAA, 1'b0, 5'd0, 32'd0, g);
        step(1'b1, 5'd10, 32'h0000_AAAA, 1'b0, 5'd0, 32'd0, g);

        // x0 targets: granted/consumed without a write, no pend bit.
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, g);
        step(1'b1, 5'd6, 32'h0000_0666, 1'b1, 5'd0, 32'hBAD0_0000, g);
        step(1'b1, 5'd12, 32'h0000_0CCC, 1'b0, 5'd0, 32'd0, g);
        step(1'b1, 5'd12, 32'h0000_0CCC, 1'b0, 5'd0, 32'd0, g);

        // Reset with the buffer full: entry dropped, clear restarts at x1.
        step(1'b1, 5'd11, 32'h0000_0BBB, 1'b1, 5'd13, 32'h0000_0DDD, g);
        do_reset(1);
        repeat (31) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);

        // Random traffic: EX holds until granted, LSU at most every other cycle.
        er = 1'b0; ea = 5'd0; ed = 32'd0; lv_prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!er && $urandom_range(0, 2) != 0) begin
                er = 1'b1;
                ea = 5'($urandom_range(0, 31));
                ed = $urandom;
            end
            lv = !lv_prev && ($urandom_range(0, 2) == 0);
            la = 5'($urandom_range(0, 31));
            ld = $urandom;
            step(er, ea, ed, lv, la, ld, g);
            if (g) er = 1'b0;
            lv_prev = lv;
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);

        for (int r = 0; r < 32; r++) begin
            chk($sformatf("rf_x%0d", r), act_rf[r], exp_rf[r]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
